// File: rtl/ram_test_pkg.sv
// ============================================================================
// ram_test_pkg: shared types and background-word helpers for the March C- BIST
// Revision: 1.0
// ============================================================================
`default_nettype none

package ram_test_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    M0 = 3'd0,
    M1 = 3'd1,
    M2 = 3'd2,
    M3 = 3'd3,
    M4 = 3'd4,
    M5 = 3'd5
  } elem_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  localparam int c_MAX_DW = 64;

  // Background word of the requested width; callers truncate to DATA_WIDTH.
  function automatic logic [c_MAX_DW-1:0] background_word(input logic i_ones, input int i_width);
    logic [c_MAX_DW-1:0] w_word;
    w_word = '0;
    for (int b = 0; b < c_MAX_DW; b++) begin
      if (b < i_width) w_word[b] = i_ones;
    end
    return w_word;
  endfunction

  function automatic logic elem_is_down(input elem_t i_e);
    return (i_e == M3) || (i_e == M4);
  endfunction

  function automatic logic elem_has_read(input elem_t i_e);
    return i_e != M0;
  endfunction

  function automatic logic elem_has_write(input elem_t i_e);
    return i_e != M5;
  endfunction

  function automatic logic elem_write_ones(input elem_t i_e);
    return (i_e == M1) || (i_e == M3);
  endfunction

  function automatic logic elem_read_ones(input elem_t i_e);
    return (i_e == M2) || (i_e == M4);
  endfunction

  function automatic elem_t elem_next(input elem_t i_e);
    elem_t w_n;
    case (i_e)
      M0:      w_n = M1;
      M1:      w_n = M2;
      M2:      w_n = M3;
      M3:      w_n = M4;
      M4:      w_n = M5;
      default: w_n = M5;
    endcase
    return w_n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_march_addr_gen.sv
// ============================================================================
// ram_march_addr_gen: wrapping up/down address counter with load and terminal count
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_march_addr_gen #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic                  i_dir_down,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_tc
);

  logic [ADDR_WIDTH-1:0] r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= '0;
    end else if (i_step) begin
      r_addr <= i_dir_down ? (r_addr - 1'b1) : (r_addr + 1'b1);
    end
  end

  assign o_addr = r_addr;
  assign o_tc   = i_dir_down ? (r_addr == '0) : (r_addr == '1);

endmodule

`default_nettype wire

// File: rtl/ram_march_tester.sv
// ============================================================================
// ram_march_tester: March C- BIST sequencer with first-failure capture
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_march_tester
  import ram_test_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_write_enable,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_address,
  output logic [DATA_WIDTH-1:0] fail_expected,
  output logic [DATA_WIDTH-1:0] fail_actual
);

  localparam logic [DATA_WIDTH-1:0] c_B0 = DATA_WIDTH'(background_word(1'b0, DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] c_B1 = DATA_WIDTH'(background_word(1'b1, DATA_WIDTH));

  state_t                r_state;
  elem_t                 r_elem;
  op_t                   r_op;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;
  logic [ADDR_WIDTH-1:0] r_fail_address;
  logic [DATA_WIDTH-1:0] r_fail_expected;
  logic [DATA_WIDTH-1:0] r_fail_actual;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_tc;
  logic                  w_load;
  logic                  w_step;
  logic                  w_running;
  logic                  w_mismatch;
  logic [DATA_WIDTH-1:0] w_exp;
  logic [DATA_WIDTH-1:0] w_wr_word;
  elem_t                 w_next_elem;

  assign w_running   = (r_state == S_RUN);
  assign w_next_elem = elem_next(r_elem);
  assign w_exp       = elem_read_ones(r_elem) ? c_B1 : c_B0;
  assign w_wr_word   = elem_write_ones(r_elem) ? c_B1 : c_B0;
  assign w_mismatch  = (ram_data_out != w_exp);

  // Across an element boundary the counter keeps walking when the direction
  // is unchanged (wrap) and holds when it reverses, so no idle cycle is needed.
  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: w_load = start;
      S_RUN: begin
        if (r_op == OP_WRITE) begin
          w_step = !w_tc || (elem_is_down(w_next_elem) == elem_is_down(r_elem));
        end else begin
          w_step = !elem_has_write(r_elem) && !w_mismatch && !w_tc;
        end
      end
      default: ;
    endcase
  end

  ram_march_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk       (clock),
    .rst_n     (reset_n),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_dir_down(elem_is_down(r_elem)),
    .o_addr    (w_addr),
    .o_tc      (w_tc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_elem          <= M0;
      r_op            <= OP_WRITE;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
      r_fail_address  <= '0;
      r_fail_expected <= '0;
      r_fail_actual   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state         <= S_RUN;
            r_elem          <= M0;
            r_op            <= OP_WRITE;
            r_busy          <= 1'b1;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_fail_address  <= '0;
            r_fail_expected <= '0;
            r_fail_actual   <= '0;
          end
        end
        S_RUN: begin
          if (r_op == OP_READ) begin
            if (w_mismatch) begin
              r_state         <= S_DONE;
              r_busy          <= 1'b0;
              r_done          <= 1'b1;
              r_pass          <= 1'b0;
              r_fail_address  <= w_addr;
              r_fail_expected <= w_exp;
              r_fail_actual   <= ram_data_out;
            end else if (elem_has_write(r_elem)) begin
              r_op <= OP_WRITE;
            end else if (w_tc) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end
          end else begin
            if (w_tc) begin
              r_elem <= w_next_elem;
              r_op   <= OP_READ;
            end else begin
              r_op <= elem_has_read(r_elem) ? OP_READ : OP_WRITE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign fail_address     = r_fail_address;
  assign fail_expected    = r_fail_expected;
  assign fail_actual      = r_fail_actual;
  assign ram_write_enable = w_running && (r_op == OP_WRITE);
  assign ram_address      = w_running ? w_addr : '0;
  assign ram_data_in      = ram_write_enable ? w_wr_word : '0;

endmodule

`default_nettype wire

// File: tb/tb_ram_march_tester.sv
// ============================================================================
// tb_ram_march_tester: scoreboard bench with a fault-injectable RAM model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ram_march_tester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  int   fault   = 0;

  logic [7:0]  din_a, dout_a, fe_a, fact_a;
  logic [3:0]  addr_a, fa_a;
  logic        we_a, busy_a, done_a, pass_a;
  logic [15:0] din_b, dout_b, fe_b, fact_b;
  logic [1:0]  addr_b, fa_b;
  logic        we_b, busy_b, done_b, pass_b;

  ram_march_tester #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) u_dut_a (
    .clock(clk), .reset_n(reset_n), .start(start_a),
    .ram_data_in(din_a), .ram_address(addr_a), .ram_write_enable(we_a),
    .ram_data_out(dout_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_address(fa_a), .fail_expected(fe_a), .fail_actual(fact_a)
  );

  ram_march_tester #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) u_dut_b (
    .clock(clk), .reset_n(reset_n), .start(start_b),
    .ram_data_in(din_b), .ram_address(addr_b), .ram_write_enable(we_b),
    .ram_data_out(dout_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_address(fa_b), .fail_expected(fe_b), .fail_actual(fact_b)
  );

  // RAM models: fault 1 = bit 3 stuck high at cell 5, fault 2 = address 9 aliases to 1
  logic [7:0]  mem_a [16];
  logic [15:0] mem_b [4];

  function automatic int eff_a(input logic [3:0] a);
    return (fault == 2 && a == 4'd9) ? 1 : int'(a);
  endfunction

  always @(posedge clk) if (we_a) mem_a[eff_a(addr_a)] <= din_a;
  always @(posedge clk) if (we_b) mem_b[addr_b] <= din_b;
  always_comb dout_a = mem_a[eff_a(addr_a)] | ((fault == 1 && eff_a(addr_a) == 5) ? 8'h08 : 8'h00);
  always_comb dout_b = mem_b[addr_b];

  logic        sel = 1'b0;
  logic        m_busy, m_done, m_pass, m_we;
  logic [3:0]  m_addr, m_fa;
  logic [15:0] m_din, m_fe, m_fact;
  always_comb begin
    m_busy = sel ? busy_b : busy_a;
    m_done = sel ? done_b : done_a;
    m_pass = sel ? pass_b : pass_a;
    m_we   = sel ? we_b : we_a;
    m_addr = sel ? {2'b00, addr_b} : addr_a;
    m_fa   = sel ? {2'b00, fa_b} : fa_a;
    m_din  = sel ? din_b : {8'h00, din_a};
    m_fe   = sel ? fe_b : {8'h00, fe_a};
    m_fact = sel ? fact_b : {8'h00, fact_a};
  end

  typedef struct packed {
    logic        we;
    logic [3:0]  addr;
    logic [15:0] data;
  } op_rec_t;

  typedef struct {
    logic        pass;
    logic [3:0]  fa;
    logic [15:0] fe;
    logic [15:0] fact;
    int          cycles;
  } result_t;

  op_rec_t op_q[$];
  result_t res_q[$];
  int total = 0;
  int bad   = 0;

  task automatic push_op(input logic we, input int a, input logic [15:0] d);
    op_rec_t o;
    o.we = we; o.addr = 4'(a); o.data = d;
    op_q.push_back(o);
  endtask

  // Expected March C- operation stream
  task automatic gen_ops(input int n, input logic [15:0] ones);
    int a;
    for (int i = 0; i < n; i++) push_op(1'b1, i, 16'h0000);
    for (int e = 1; e <= 4; e++) begin
      for (int i = 0; i < n; i++) begin
        a = (e >= 3) ? (n - 1 - i) : i;
        push_op(1'b0, a, 16'h0000);
        push_op(1'b1, a, (e == 1 || e == 3) ? ones : 16'h0000);
      end
    end
    for (int i = 0; i < n; i++) push_op(1'b0, i, 16'h0000);
  endtask

  task automatic push_result(input logic p, input logic [3:0] fa, input logic [15:0] fe,
                             input logic [15:0] fact, input int cycles);
    result_t r;
    r.pass = p; r.fa = fa; r.fe = fe; r.fact = fact; r.cycles = cycles;
    res_q.push_back(r);
  endtask

  task automatic run(input logic s, input bit chk_stream, input bit hold);
    result_t exp_r;
    op_rec_t o;
    int      cycles;
    sel = s;
    @(negedge clk);
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
    total++;
    if (m_busy !== 1'b1 || m_done !== 1'b0) begin
      bad++; $display("FAIL start_edge: busy=%b done=%b want busy=1 done=0", m_busy, m_done);
    end
    cycles = 0;
    while (m_done !== 1'b1 && cycles < 400) begin
      if (chk_stream && m_busy === 1'b1) begin
        total++;
        if (op_q.size() == 0) begin
          bad++; $display("FAIL stream_extra: cycle %0d we=%b addr=%0d, want no op", cycles, m_we, m_addr);
        end else begin
          o = op_q.pop_front();
          if (m_we !== o.we || m_addr !== o.addr || (o.we && m_din !== o.data)) begin
            bad++;
            $display("FAIL stream_op: cycle %0d got we=%b addr=%0d data=%h want we=%b addr=%0d data=%h",
                     cycles, m_we, m_addr, m_din, o.we, o.addr, o.data);
          end
        end
      end
      @(posedge clk); #1;
      cycles++;
    end
    start_a = 1'b0; start_b = 1'b0;
    exp_r = res_q.pop_front();
    total++;
    if (cycles !== exp_r.cycles) begin
      bad++; $display("FAIL run_length: got %0d cycles want %0d", cycles, exp_r.cycles);
    end
    total++;
    if (m_busy !== 1'b0 || m_pass !== exp_r.pass) begin
      bad++; $display("FAIL result_pass: busy=%b pass=%b want busy=0 pass=%b", m_busy, m_pass, exp_r.pass);
    end
    total++;
    if (m_fa !== exp_r.fa || m_fe !== exp_r.fe || m_fact !== exp_r.fact) begin
      bad++;
      $display("FAIL result_capture: addr=%0d exp=%h act=%h want addr=%0d exp=%h act=%h",
               m_fa, m_fe, m_fact, exp_r.fa, exp_r.fe, exp_r.fact);
    end
    if (chk_stream) begin
      total++;
      if (op_q.size() != 0) begin
        bad++; $display("FAIL stream_short: %0d ops left, want 0", op_q.size());
        op_q.delete();
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy_a, done_a, pass_a, we_a, addr_a, din_a, fa_a, fe_a, fact_a} !== '0) begin
      bad++; $display("FAIL reset_a: busy=%b done=%b pass=%b we=%b addr=%h want all 0", busy_a, done_a, pass_a, we_a, addr_a);
    end
    total++;
    if ({busy_b, done_b, pass_b, we_b, addr_b, din_b, fa_b, fe_b, fact_b} !== '0) begin
      bad++; $display("FAIL reset_b: busy=%b done=%b pass=%b we=%b addr=%h want all 0", busy_b, done_b, pass_b, we_b, addr_b);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_good_ram;
    int nz;
    fault = 0;
    gen_ops(16, 16'h00FF);
    push_result(1'b1, 4'd0, 16'h0, 16'h0, 160);
    run(1'b0, 1'b1, 1'b0);
    nz = 0;
    for (int i = 0; i < 16; i++) if (mem_a[i] !== 8'h00) nz++;
    total++;
    if (nz != 0) begin
      bad++; $display("FAIL final_ram: %0d nonzero cells, want 0", nz);
    end
  endtask

  task automatic test_stuck_at;
    fault = 1;
    push_result(1'b0, 4'd5, 16'h0000, 16'h0008, 27);
    run(1'b0, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      total++;
      if (we_a !== 1'b0 || addr_a !== 4'd0 || din_a !== 8'h00 || done_a !== 1'b1) begin
        bad++; $display("FAIL done_quiet: we=%b addr=%0d din=%h done=%b want 0/0/00/1", we_a, addr_a, din_a, done_a);
      end
    end
  endtask

  task automatic test_alias;
    fault = 2;
    push_result(1'b0, 4'd9, 16'h0000, 16'h00FF, 35);
    run(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_run;
    fault = 0;
    sel   = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (51) @(posedge clk);
    #1;
    total++;
    if (we_a !== 1'b1 || busy_a !== 1'b1) begin
      bad++; $display("FAIL pre_reset: we=%b busy=%b want 1/1", we_a, busy_a);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (busy_a !== 1'b0 || we_a !== 1'b0 || done_a !== 1'b0 || addr_a !== 4'd0) begin
      bad++; $display("FAIL async_reset: busy=%b we=%b done=%b addr=%0d want 0", busy_a, we_a, done_a, addr_a);
    end
    @(negedge clk);
    reset_n = 1'b1;
    gen_ops(16, 16'h00FF);
    push_result(1'b1, 4'd0, 16'h0, 16'h0, 160);
    run(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_start_behaviour;
    fault = 0;
    push_result(1'b1, 4'd0, 16'h0, 16'h0, 160);
    run(1'b0, 1'b0, 1'b1);
    gen_ops(16, 16'h00FF);
    push_result(1'b1, 4'd0, 16'h0, 16'h0, 160);
    run(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_wide;
    gen_ops(4, 16'hFFFF);
    push_result(1'b1, 4'd0, 16'h0, 16'h0, 40);
    run(1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_good_ram();
    test_stuck_at();
    test_alias();
    test_reset_mid_run();
    test_start_behaviour();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
